ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single 512x8 block RAM between two requesters: port 0 is the cpu and port 1 is the UART loader/monitor.
- Issues at most one access per clock, either a read or a write.
- Returns read data to the issuing port after a fixed latency.
- Arbitrates round-robin, with a bounded burst hold so one port cannot starve the other.
- Sits between the requesters and the RAM's raddr/waddr/dwrite/write_en/dread pins.

Parameters:
- AW, 9, address width.
- DW, 8, data width.
- RD_LAT, 2, cycles from the accept edge to rvalid; must match the RAM's registered-read latency; minimum 1.
- MAX_BURST, 4, maximum number of consecutive accepts for one port while the other port is requesting; minimum 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low; rst==0 at a posedge resets the block.
- m0_req  in  1  port 0 access request; held until accepted.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  AW  access address.
- m0_wdata  in  DW  write data.
- m0_gnt  out  1  combinational; m0_req && m0_gnt at a posedge = accepted.
- m0_rvalid  out  1  one-cycle pulse; m0_rdata is valid.
- m0_rdata  out  DW  read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical to port 0, for port 1.
- ram_raddr  out  AW  registered RAM read address.
- ram_waddr  out  AW  registered RAM write address.
- ram_dwrite  out  DW  registered RAM write data.
- ram_write_en  out  1  registered one-cycle write strobe.
- ram_dread  in  DW  RAM read data.

Behaviour:
- Reset (rst==0 at a posedge):
  - ram_raddr, ram_waddr, ram_dwrite, ram_write_en, m*_rvalid, m*_rdata go to 0.
  - last_owner goes to 1, so port 0 wins the first tie.
  - burst_cnt goes to 0 and the read tag pipeline is cleared.
  - Reads in flight are dropped; no rvalid is ever produced for them.
  - gnt is 0 while rst==0.
- Grant, combinational, at most one gnt high:
  - Only one port requesting: that port is granted.
  - Both requesting, owner==last_owner and burst_cnt<MAX_BURST: grant last_owner.
  - Both requesting otherwise: grant the other port.
  - Neither requesting: no gnt.
- On accept of port p:
  - Update last_owner to p.
  - burst_cnt becomes burst_cnt+1 if p==last_owner, else 1. It saturates at MAX_BURST.
  - A cycle with no accept resets burst_cnt to 0.
- Write accept:
  - Next cycle: ram_waddr=addr, ram_dwrite=wdata, ram_write_en=1 for exactly one cycle.
  - No read data or rvalid is produced for a write.
- Read accept:
  - Next cycle: ram_raddr=addr. ram_raddr holds its value when there is no read accept.
  - A tag {valid=1, port=p} enters an RD_LAT-deep shift register; idle cycles shift in valid=0.
- At the tag-register output with valid=1:
  - Assert m<port>_rvalid for one cycle and present rdata=ram_dread.
  - rdata is registered and latches only when rvalid is asserted, otherwise it holds.
- Throughput and latency:
  - One accept per cycle is sustained, including back-to-back reads from alternating ports.
  - Read results return in issue order.
  - Latency is exactly RD_LAT+1 edges from the accept edge to the rvalid-high cycle, independent of other traffic.
- Ordering between ports:
  - A read accepted the cycle after a write to the same address returns the new data, because the RAM write happens before the read address is sampled.
  - Accesses occupy separate cycles, so there are no same-cycle collisions.
- Request rules:
  - A requester may change addr/we/wdata, or drop req, only after acceptance.
  - A req dropped before grant is simply never served.
- Single requester: it is accepted every cycle it requests; MAX_BURST does not limit it.

Decomposition:
- Shared package ram_arb_pkg:
  - AW, DW, RD_LAT defaults.
  - Port-index localparams PORT_CPU=0, PORT_MON=1.
  - A tag struct {valid, port}.
- One natural sub-module, rd_tag_pipe: an RD_LAT-deep tag shift register with synchronous active-low clear.
- Arbitration and the RAM output registers stay in the top module.

Test Plan:
- Port 0 writes addr 0x05 data 0xA5, then port 0 reads 0x05 -> ram_write_en pulses once with waddr=0x05; m0_rvalid goes high 3 edges after the read accept with m0_rdata=0xA5; m1_rvalid stays 0.
- Both ports hold req continuously with reads, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0,...; every accept yields exactly one rvalid on the correct port in issue order.
- Port 1 alone requests 10 consecutive reads of 0x100..0x109 -> granted every cycle with no gaps; rdata matches preloaded RAM contents in order.
- Write 0x3C to 0x1FF by port 1, then the next-cycle read of 0x1FF by port 0 -> m0_rdata=0x3C; the address wraps nowhere and the top address is handled.
- rst driven low for one cycle with two reads in flight -> no rvalid for either read, ram_write_en=0, and the next tie is granted to port 0.
- Port 0 asserts req then drops it before grant while port 1 holds a burst -> port 0 is never accepted and no spurious RAM write occurs.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port block-RAM arbiter.
package ram_arb_pkg;

    localparam int RAM_AW     = 9;
    localparam int RAM_DW     = 8;
    localparam int RAM_RD_LAT = 2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_MON = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register carrying read tags alongside the RAM's read latency.
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = RAM_RD_LAT
)(
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [DEPTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one registered-read block RAM between the cpu and the UART monitor.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW        = RAM_AW,
    parameter int DW        = RAM_DW,
    parameter int RD_LAT    = RAM_RD_LAT,
    parameter int MAX_BURST = 4
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_raddr,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_dwrite,
    output logic          ram_write_en,
    input  logic [DW-1:0] ram_dread
);

    localparam int CW = $clog2(MAX_BURST + 1);

    logic          last_owner;
    logic [CW-1:0] burst_cnt;
    logic          hold;
    logic          tie_port;
    logic          accept;
    logic          acc_port;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    rd_tag_t       issue_tag;
    rd_tag_t       tag_out;

    // A tie stays with the owner only mid-burst; after an idle cycle it rotates.
    assign hold     = (burst_cnt != '0) && (burst_cnt < CW'(MAX_BURST));
    assign tie_port = hold ? last_owner : !last_owner;

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst) begin
            if (m0_req && m1_req) begin
                m0_gnt = (tie_port == PORT_CPU);
                m1_gnt = (tie_port == PORT_MON);
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    assign accept    = (m0_req && m0_gnt) || (m1_req && m1_gnt);
    assign acc_port  = (m1_req && m1_gnt) ? PORT_MON : PORT_CPU;
    assign acc_we    = (acc_port == PORT_MON) ? m1_we    : m0_we;
    assign acc_addr  = (acc_port == PORT_MON) ? m1_addr  : m0_addr;
    assign acc_wdata = (acc_port == PORT_MON) ? m1_wdata : m0_wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner <= 1'b1;
            burst_cnt  <= '0;
        end else if (accept) begin
            last_owner <= acc_port;
            if (acc_port == last_owner) begin
                if (burst_cnt != CW'(MAX_BURST)) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                burst_cnt <= CW'(1);
            end
        end else begin
            burst_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_raddr       <= '0;
            ram_waddr       <= '0;
            ram_dwrite      <= '0;
            ram_write_en    <= 1'b0;
            issue_tag       <= '0;
        end else begin
            ram_write_en    <= accept && acc_we;
            issue_tag.valid <= accept && !acc_we;
            issue_tag.port  <= acc_port;
            if (accept && acc_we) begin
                ram_waddr  <= acc_addr;
                ram_dwrite <= acc_wdata;
            end
            if (accept && !acc_we) begin
                ram_raddr <= acc_addr;
            end
        end
    end

    // issue_tag is aligned with ram_raddr, so after RD_LAT more stages it lines up with ram_dread.
    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (issue_tag),
        .tag_out (tag_out)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= tag_out.valid && (tag_out.port == PORT_CPU);
            m1_rvalid <= tag_out.valid && (tag_out.port == PORT_MON);
            if (tag_out.valid && (tag_out.port == PORT_CPU)) begin
                m0_rdata <= ram_dread;
            end
            if (tag_out.valid && (tag_out.port == PORT_MON)) begin
                m1_rdata <= ram_dread;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a two-cycle registered-read RAM model.
`timescale 1ns/1ps
module tb_ram_arbiter;

    logic       clk;
    logic       rst;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [8:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata;
    logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [7:0] m0_rdata, m1_rdata;
    logic [8:0] ram_raddr, ram_waddr;
    logic [7:0] ram_dwrite, ram_dread;
    logic       ram_write_en;

    logic [7:0] mem [512];
    logic [7:0] rd_stage;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(
        .AW        (9),
        .DW        (8),
        .RD_LAT    (2),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_gnt       (m0_gnt),
        .m0_rvalid    (m0_rvalid),
        .m0_rdata     (m0_rdata),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_gnt       (m1_gnt),
        .m1_rvalid    (m1_rvalid),
        .m1_rdata     (m1_rdata),
        .ram_raddr    (ram_raddr),
        .ram_waddr    (ram_waddr),
        .ram_dwrite   (ram_dwrite),
        .ram_write_en (ram_write_en),
        .ram_dread    (ram_dread)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM model: write on the strobe, read data two edges after ram_raddr is presented.
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_waddr] <= ram_dwrite;
        rd_stage  <= mem[ram_raddr];
        ram_dread <= rd_stage;
    end

    task automatic applyStimulus(input logic r0, input logic w0, input logic [8:0] a0, input logic [7:0] d0,
                                 input logic r1, input logic w1, input logic [8:0] a1, input logic [7:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00);
    endtask

    logic rr_seq [9];

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        for (int i = 0; i < 10; i++) mem[9'h100 + i] = 8'h40 + 8'(i);
        mem[9'h010] = 8'h11;
        mem[9'h020] = 8'h22;
        rr_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

        // Reset state
        rst = 1'b0;
        applyStimulus(1, 0, 9'h005, 8'h00, 1, 0, 9'h006, 8'h00);
        checkOutput("rst_gnt0", 16'(m0_gnt), 16'h0);
        checkOutput("rst_gnt1", 16'(m1_gnt), 16'h0);
        tick();
        tick();
        checkOutput("rst_raddr", 16'(ram_raddr), 16'h0);
        checkOutput("rst_waddr", 16'(ram_waddr), 16'h0);
        checkOutput("rst_dwrite", 16'(ram_dwrite), 16'h0);
        checkOutput("rst_wen", 16'(ram_write_en), 16'h0);
        checkOutput("rst_rvalid0", 16'(m0_rvalid), 16'h0);
        checkOutput("rst_rvalid1", 16'(m1_rvalid), 16'h0);
        checkOutput("rst_rdata0", 16'(m0_rdata), 16'h0);
        checkOutput("rst_rdata1", 16'(m1_rdata), 16'h0);
        idle();
        rst = 1'b1;
        tick();

        // Port 0 write 0x05 <= 0xA5, then read it back
        applyStimulus(1, 1, 9'h005, 8'hA5, 0, 0, 9'h000, 8'h00);
        checkOutput("t1_wr_gnt0", 16'(m0_gnt), 16'h1);
        checkOutput("t1_wr_gnt1", 16'(m1_gnt), 16'h0);
        tick();
        checkOutput("t1_wen", 16'(ram_write_en), 16'h1);
        checkOutput("t1_waddr", 16'(ram_waddr), 16'h005);
        checkOutput("t1_dwrite", 16'(ram_dwrite), 16'hA5);
        applyStimulus(1, 0, 9'h005, 8'h00, 0, 0, 9'h000, 8'h00);
        checkOutput("t1_rd_gnt0", 16'(m0_gnt), 16'h1);
        tick();
        checkOutput("t1_wen_once", 16'(ram_write_en), 16'h0);
        checkOutput("t1_raddr", 16'(ram_raddr), 16'h005);
        idle();
        tick();
        checkOutput("t1_rvalid_e2", 16'(m0_rvalid), 16'h0);
        tick();
        checkOutput("t1_rvalid_e3", 16'(m0_rvalid), 16'h0);
        tick();
        checkOutput("t1_rvalid_e4", 16'(m0_rvalid), 16'h1);
        checkOutput("t1_rdata", 16'(m0_rdata), 16'hA5);
        checkOutput("t1_rvalid1", 16'(m1_rvalid), 16'h0);
        tick();
        checkOutput("t1_rvalid_pulse", 16'(m0_rvalid), 16'h0);
        checkOutput("t1_rdata_hold", 16'(m0_rdata), 16'hA5);
        checkOutput("t1_raddr_hold", 16'(ram_raddr), 16'h005);

        // Port 1 alone: ten back-to-back reads of 0x100..0x109
        for (int i = 0; i < 13; i++) begin
            if (i < 10) begin
                applyStimulus(0, 0, 9'h000, 8'h00, 1, 0, 9'h100 + 9'(i), 8'h00);
                checkOutput($sformatf("t3_gnt1_%0d", i), 16'(m1_gnt), 16'h1);
            end else begin
                idle();
            end
            tick();
            if (i >= 3) begin
                checkOutput($sformatf("t3_rvalid1_%0d", i), 16'(m1_rvalid), 16'h1);
                checkOutput($sformatf("t3_rdata1_%0d", i), 16'(m1_rdata), 16'h40 + 16'(i - 3));
                checkOutput($sformatf("t3_rvalid0_%0d", i), 16'(m0_rvalid), 16'h0);
            end
        end
        tick();
        checkOutput("t3_drained", 16'(m1_rvalid), 16'h0);

        // Port 1 writes 0x3C to 0x1FF, port 0 reads 0x1FF the next cycle
        applyStimulus(0, 0, 9'h000, 8'h00, 1, 1, 9'h1FF, 8'h3C);
        checkOutput("t4_gnt1", 16'(m1_gnt), 16'h1);
        tick();
        checkOutput("t4_wen", 16'(ram_write_en), 16'h1);
        checkOutput("t4_waddr", 16'(ram_waddr), 16'h1FF);
        applyStimulus(1, 0, 9'h1FF, 8'h00, 0, 0, 9'h000, 8'h00);
        checkOutput("t4_gnt0", 16'(m0_gnt), 16'h1);
        tick();
        idle();
        tick();
        tick();
        tick();
        checkOutput("t4_rvalid0", 16'(m0_rvalid), 16'h1);
        checkOutput("t4_rdata0", 16'(m0_rdata), 16'h3C);
        tick();

        // Port 0 pulses a write request that loses to port 1, then withdraws it
        applyStimulus(1, 1, 9'h005, 8'hFF, 1, 0, 9'h020, 8'h00);
        checkOutput("t6_tie_gnt0", 16'(m0_gnt), 16'h0);
        checkOutput("t6_tie_gnt1", 16'(m1_gnt), 16'h1);
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 0) applyStimulus(0, 0, 9'h000, 8'h00, 1, 0, 9'h020, 8'h00);
            if (i == 4) idle();
            checkOutput($sformatf("t6_wen_%0d", i), 16'(ram_write_en), 16'h0);
            checkOutput($sformatf("t6_rvalid0_%0d", i), 16'(m0_rvalid), 16'h0);
        end
        checkOutput("t6_mem_untouched", 16'(mem[9'h005]), 16'hA5);

        // Two reads in flight, then a one-cycle reset
        applyStimulus(1, 0, 9'h010, 8'h00, 0, 0, 9'h000, 8'h00);
        tick();
        applyStimulus(0, 0, 9'h000, 8'h00, 1, 0, 9'h020, 8'h00);
        tick();
        idle();
        rst = 1'b0;
        #1;
        checkOutput("t5_gnt_in_rst", 16'(m1_gnt), 16'h0);
        tick();
        rst = 1'b1;
        checkOutput("t5_raddr_rst", 16'(ram_raddr), 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("t5_rvalid0_%0d", i), 16'(m0_rvalid), 16'h0);
            checkOutput($sformatf("t5_rvalid1_%0d", i), 16'(m1_rvalid), 16'h0);
            checkOutput($sformatf("t5_wen_%0d", i), 16'(ram_write_en), 16'h0);
        end

        // Both ports hold read requests: 4-deep bursts alternating, port 0 first after reset
        applyStimulus(1, 0, 9'h010, 8'h00, 1, 0, 9'h020, 8'h00);
        for (int k = 0; k < 12; k++) begin
            if (k < 9) begin
                checkOutput($sformatf("t2_gnt0_%0d", k), 16'(m0_gnt), 16'(!rr_seq[k]));
                checkOutput($sformatf("t2_gnt1_%0d", k), 16'(m1_gnt), 16'(rr_seq[k]));
            end
            tick();
            if (k == 8) idle();
            if (k >= 3) begin
                checkOutput($sformatf("t2_rvalid0_%0d", k), 16'(m0_rvalid), 16'(!rr_seq[k-3]));
                checkOutput($sformatf("t2_rvalid1_%0d", k), 16'(m1_rvalid), 16'(rr_seq[k-3]));
                if (rr_seq[k-3]) checkOutput($sformatf("t2_rdata1_%0d", k), 16'(m1_rdata), 16'h22);
                else             checkOutput($sformatf("t2_rdata0_%0d", k), 16'(m0_rdata), 16'h11);
            end
        end
        tick();
        checkOutput("t2_drained0", 16'(m0_rvalid), 16'h0);
        checkOutput("t2_drained1", 16'(m1_rvalid), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
